// File: rtl/daisy_link_ctrl_if.sv
// Bus port bundle between the link sequencer (master) and the daisy register block (slave).
interface daisy_link_ctrl_if;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_sel;
  logic        m_wen;
  logic        m_ren;
  logic [31:0] m_rdata;
  logic        m_ack;
  logic        m_err;

  modport master (output m_addr, m_wdata, m_sel, m_wen, m_ren,
                  input  m_rdata, m_ack, m_err);
  modport slave  (input  m_addr, m_wdata, m_sel, m_wen, m_ren,
                  output m_rdata, m_ack, m_err);
endinterface

// File: rtl/daisy_link_ctrl.sv
// Autonomous bring-up sequencer for the daisy-chain serial link (bus master on sys_clk_i).
// Optional DAISY_LINK_CTRL_MONITOR_EN: periodic error-count recheck while the link is up.
module daisy_link_ctrl #(
  parameter int POLL_CYC    = 1024,
  parameter int TRAIN_POLLS = 64,
  parameter int TEST_CYC    = 65536,
  parameter int MIN_DAT     = 1000,
  parameter int MAX_RETRY   = 3,
  parameter int BUS_TMO     = 255
) (
  input  logic              sys_clk_i,
  input  logic              sys_rstn_i,
  input  logic              start_i,
  input  logic              stop_i,
  daisy_link_ctrl_if.master bus,
  output logic              busy_o,
  output logic              link_up_o,
  output logic              fail_o,
  output logic [2:0]        err_code_o,
  output logic [1:0]        retry_cnt_o,
  output logic [31:0]       err_cnt_o
);
  localparam int TMO_W  = $clog2(BUS_TMO + 1);
  localparam int POLL_W = $clog2(TRAIN_POLLS + 1);

  typedef enum logic [4:0] {
    ST_IDLE, ST_EN, ST_SEL_TRN, ST_TRN_ON, ST_POLL, ST_TRN_OFF, ST_SEL_TST,
    ST_CLR1, ST_CLR0, ST_TEST, ST_RD_ERR, ST_RD_DAT, ST_SEL_USR, ST_LINK_UP,
    ST_RETRY, ST_STOP, ST_FAIL
  } state_t;

  state_t              state_q, state_d;
  logic                pend_q, pend_d, stop_q, stop_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [31:0]         wait_q, wait_d, wait_lim;
  logic [POLL_W-1:0]   poll_q, poll_d;
  logic [1:0]          retry_q, retry_d;
  logic [2:0]          code_q, code_d;
  logic [31:0]         ecnt_q, ecnt_d, wdata_q, wdata_d, op_wdata;
  logic [4:0]          addr_q, addr_d, op_addr;
  logic                wen_q, wen_d, ren_q, ren_d, op_wr, op_rd;
  logic                busy_q, busy_d, link_q, link_d, fail_q, fail_d;
  logic                wait_done, stop_any, adv;

  assign bus.m_addr   = {27'd0, addr_q};
  assign bus.m_wdata  = wdata_q;
  assign bus.m_sel    = 4'hF;
  assign bus.m_wen    = wen_q;
  assign bus.m_ren    = ren_q;
  assign busy_o       = busy_q;
  assign link_up_o    = link_q;
  assign fail_o       = fail_q;
  assign err_code_o   = code_q;
  assign retry_cnt_o  = retry_q;
  assign err_cnt_o    = ecnt_q;

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;   stop_q  <= 1'b0;  tmo_q  <= '0;    wait_q <= '0;
      poll_q  <= '0;     retry_q <= '0;    code_q <= '0;    ecnt_q <= '0;
      addr_q  <= '0;     wdata_q <= '0;    wen_q  <= 1'b0;  ren_q  <= 1'b0;
      busy_q  <= 1'b0;   link_q  <= 1'b0;  fail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;  stop_q  <= stop_d;  tmo_q  <= tmo_d;   wait_q <= wait_d;
      poll_q  <= poll_d;  retry_q <= retry_d; code_q <= code_d;  ecnt_q <= ecnt_d;
      addr_q  <= addr_d;  wdata_q <= wdata_d; wen_q  <= wen_d;   ren_q  <= ren_d;
      busy_q  <= busy_d;  link_q  <= link_d;  fail_q <= fail_d;
    end
  end

  always_comb begin
    // per-state bus access and pre-access wait
    op_wr = 1'b0; op_rd = 1'b0; op_addr = 5'h00; op_wdata = 32'd0; wait_lim = 32'd0;
    case (state_q)
      ST_EN:      begin op_wr = 1'b1; op_addr = 5'h00; op_wdata = 32'd3; end
      ST_SEL_TRN: begin op_wr = 1'b1; op_addr = 5'h04; op_wdata = 32'd3; end
      ST_TRN_ON:  begin op_wr = 1'b1; op_addr = 5'h08; op_wdata = 32'd1; end
      ST_POLL:    begin op_rd = 1'b1; op_addr = 5'h08; wait_lim = 32'(POLL_CYC); end
      ST_TRN_OFF: begin op_wr = 1'b1; op_addr = 5'h08; op_wdata = 32'd0; end
      ST_SEL_TST: begin op_wr = 1'b1; op_addr = 5'h04; op_wdata = 32'd5; end
      ST_CLR1:    begin op_wr = 1'b1; op_addr = 5'h10; op_wdata = 32'd1; end
      ST_CLR0:    begin op_wr = 1'b1; op_addr = 5'h10; op_wdata = 32'd0; end
      ST_TEST:    wait_lim = 32'(TEST_CYC);
      ST_RD_ERR:  begin op_rd = 1'b1; op_addr = 5'h14; end
      ST_RD_DAT:  begin op_rd = 1'b1; op_addr = 5'h18; end
      ST_SEL_USR: begin op_wr = 1'b1; op_addr = 5'h04; op_wdata = 32'd1; end
      ST_RETRY,
      ST_STOP:    op_wr = 1'b1;
`ifdef DAISY_LINK_CTRL_MONITOR_EN
      ST_LINK_UP: begin op_rd = 1'b1; op_addr = 5'h14; wait_lim = 32'(TEST_CYC); end
`endif
      default:    ;
    endcase

    wait_done = (wait_q == wait_lim);
    stop_any  = stop_i | stop_q;
    state_d = state_q;  adv = 1'b0;  pend_d = pend_q;  tmo_d = tmo_q;
    wait_d  = wait_done ? wait_q : wait_q + 32'd1;
    poll_d  = poll_q;   retry_d = retry_q;  code_d = code_q;  ecnt_d = ecnt_q;
    addr_d  = addr_q;   wdata_d = wdata_q;  wen_d = 1'b0;     ren_d = 1'b0;

    if (pend_q) begin
      if (bus.m_ack || tmo_q == TMO_W'(BUS_TMO)) begin
        pend_d = 1'b0;
        // an abort request outranks both bus faults and normal sequencing
        if (state_q == ST_STOP)               state_d = ST_IDLE;
        else if (stop_any)                    state_d = ST_STOP;
        else if (!bus.m_ack || bus.m_err) begin state_d = ST_FAIL; code_d = 3'd1; end
        else begin
          adv = 1'b1;
          case (state_q)
            ST_EN:      state_d = ST_SEL_TRN;
            ST_SEL_TRN: state_d = ST_TRN_ON;
            ST_TRN_ON:  state_d = ST_POLL;
            ST_POLL:
              if (bus.m_rdata[4]) state_d = ST_TRN_OFF;
              else if (poll_q == POLL_W'(TRAIN_POLLS - 1)) begin
                state_d = ST_RETRY; code_d = 3'd2;
              end else poll_d = poll_q + POLL_W'(1);
            ST_TRN_OFF: state_d = ST_SEL_TST;
            ST_SEL_TST: state_d = ST_CLR1;
            ST_CLR1:    state_d = ST_CLR0;
            ST_CLR0:    state_d = ST_TEST;
            ST_RD_ERR:  begin ecnt_d = bus.m_rdata; state_d = ST_RD_DAT; end
            ST_RD_DAT:
              if (ecnt_q != 32'd0)                   begin state_d = ST_RETRY; code_d = 3'd3; end
              else if (bus.m_rdata < 32'(MIN_DAT))   begin state_d = ST_RETRY; code_d = 3'd4; end
              else                                   state_d = ST_SEL_USR;
            ST_SEL_USR: begin state_d = ST_LINK_UP; code_d = 3'd0; end
            ST_RETRY:
              if (retry_q == 2'(MAX_RETRY)) state_d = ST_FAIL;
              else begin retry_d = retry_q + 2'd1; state_d = ST_EN; end
`ifdef DAISY_LINK_CTRL_MONITOR_EN
            ST_LINK_UP:
              if (bus.m_rdata != ecnt_q) begin
                ecnt_d = bus.m_rdata; code_d = 3'd5; state_d = ST_RETRY;
              end
`endif
            default:    state_d = ST_IDLE;
          endcase
        end
      end else tmo_d = tmo_q + TMO_W'(1);
    end else if (stop_any && state_q != ST_STOP) begin
      state_d = ST_STOP;
    end else if (start_i && (state_q == ST_IDLE || state_q == ST_LINK_UP || state_q == ST_FAIL)) begin
      state_d = ST_EN; retry_d = 2'd0; code_d = 3'd0;
    end else if ((op_wr || op_rd) && wait_done) begin
      pend_d = 1'b1; tmo_d = '0; addr_d = op_addr; wdata_d = op_wdata;
      wen_d  = op_wr; ren_d = op_rd;
    end else if (state_q == ST_TEST && wait_done) begin
      state_d = ST_RD_ERR;
    end

    if (state_d != state_q) adv = 1'b1;
    if (adv) wait_d = '0;
    if (adv && state_d == ST_EN) poll_d = '0;
    stop_d = stop_any & (state_d != ST_STOP);
    busy_d = !(state_d inside {ST_IDLE, ST_LINK_UP, ST_FAIL});
    link_d = (state_d == ST_LINK_UP);
    fail_d = (state_d == ST_FAIL);
  end
endmodule

// File: tb/tb_daisy_link_ctrl.sv
// Directed bench for daisy_link_ctrl: scenario table plus hand sequences for stop, timeout, reset.
module tb_daisy_link_ctrl;
  localparam int BUS_TMO = 255;

  logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, stop_i = 1'b0;
  logic busy_o, link_up_o, fail_o;
  logic [2:0] err_code_o;
  logic [1:0] retry_cnt_o;
  logic [31:0] err_cnt_o;
  daisy_link_ctrl_if bus();

  daisy_link_ctrl #(.POLL_CYC(4), .TRAIN_POLLS(64), .TEST_CYC(40), .MIN_DAT(1000),
                    .MAX_RETRY(3), .BUS_TMO(BUS_TMO)) dut (
    .sys_clk_i(clk), .sys_rstn_i(rst_n), .start_i(start_i), .stop_i(stop_i), .bus(bus),
    .busy_o(busy_o), .link_up_o(link_up_o), .fail_o(fail_o), .err_code_o(err_code_o),
    .retry_cnt_o(retry_cnt_o), .err_cnt_o(err_cnt_o));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit we; logic [31:0] addr; logic [31:0] data; } txn_t;
  typedef struct { int trn_at; logic [31:0] e0, e1, dat;
                   bit x_lu, x_fail; logic [2:0] x_code; logic [1:0] x_retry; logic [31:0] x_ecnt; } vec_t;

  // slave model state
  txn_t        log_q[$];
  int          s_trn_at, s_polls, clr_idx, n_strobe, strobe_cyc;
  logic [31:0] err_tab[4];
  logic [31:0] s_err, s_dat;
  bit          noack_04;
  int          n_chk = 0, n_err = 0;

  initial begin
    bus.m_ack = 1'b0; bus.m_err = 1'b0; bus.m_rdata = 32'd0;
    forever begin
      @(negedge clk);
      bus.m_ack = 1'b0;
      if (rst_n && (bus.m_wen || bus.m_ren)) begin
        n_strobe++; strobe_cyc = cyc;
        log_q.push_back('{bus.m_wen, bus.m_addr, bus.m_wdata});
        if (bus.m_wen) begin
          if (bus.m_addr == 32'h08 && bus.m_wdata == 32'd1) s_polls = 0;
          if (bus.m_addr == 32'h10 && bus.m_wdata == 32'd1) begin
            s_err = err_tab[clr_idx]; if (clr_idx < 3) clr_idx++;
          end
          if (!(noack_04 && bus.m_addr == 32'h04)) bus.m_ack = 1'b1;
        end else begin
          case (bus.m_addr)
            32'h08: begin s_polls++;
                      bus.m_rdata = (s_trn_at != 0 && s_polls >= s_trn_at) ? 32'h10 : 32'hEF; end
            32'h14: bus.m_rdata = s_err;
            32'h18: bus.m_rdata = s_dat;
            default: bus.m_rdata = 32'd0;
          endcase
          bus.m_ack = 1'b1;
        end
      end
    end
  end

  task automatic tick(); @(negedge clk); #1; endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++; $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start_i = 1'b0; stop_i = 1'b0;
    log_q.delete(); s_polls = 0; clr_idx = 0; n_strobe = 0; strobe_cyc = 0;
    s_err = 32'd0; noack_04 = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1; tick();
  endtask

  task automatic cfg(input int trn_at, input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] dat);
    s_trn_at = trn_at; s_dat = dat;
    err_tab[0] = e0; err_tab[1] = e1; err_tab[2] = e1; err_tab[3] = e1;
  endtask

  task automatic pulse(input logic st, input logic sp);
    start_i = st; stop_i = sp; tick(); start_i = 1'b0; stop_i = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int lim);
    int i;
    for (i = 0; i < lim; i++) begin tick(); if (!busy_o) break; end
    chk({name, " idle within bound"}, 32'(i < lim), 32'd1);
  endtask

  task automatic wait_log(input string name, input int n, input int lim);
    int i;
    for (i = 0; i < lim && log_q.size() < n; i++) tick();
    chk({name, " bus access seen"}, 32'(log_q.size() >= n), 32'd1);
  endtask

  task automatic run_nominal();
    do_reset(); cfg(3, 32'd0, 32'd0, 32'd5000); pulse(1'b1, 1'b0); wait_idle("nominal", 20000);
  endtask

  vec_t vecs[7];
  txn_t exp_tx[13];

  initial begin
    int i, n;
    vecs = '{
      '{3,  32'd0, 32'd0, 32'd5000, 1'b1, 1'b0, 3'd0, 2'd0, 32'd0},  // nominal
      '{0,  32'd0, 32'd0, 32'd5000, 1'b0, 1'b1, 3'd2, 2'd3, 32'd0},  // never trains
      '{3,  32'd7, 32'd0, 32'd5000, 1'b1, 1'b0, 3'd0, 2'd1, 32'd0},  // errors once
      '{2,  32'd9, 32'd9, 32'd5000, 1'b0, 1'b1, 3'd3, 2'd3, 32'd9},  // errors always
      '{1,  32'd0, 32'd0, 32'd999,  1'b0, 1'b1, 3'd4, 2'd3, 32'd0},  // data one short
      '{1,  32'd0, 32'd0, 32'd1000, 1'b1, 1'b0, 3'd0, 2'd0, 32'd0},  // data exactly minimum
      '{64, 32'd0, 32'd0, 32'd5000, 1'b1, 1'b0, 3'd0, 2'd0, 32'd0}   // trains on last poll
    };
    exp_tx = '{'{1'b1, 32'h00, 32'd3}, '{1'b1, 32'h04, 32'd3}, '{1'b1, 32'h08, 32'd1},
               '{1'b0, 32'h08, 32'd0}, '{1'b0, 32'h08, 32'd0}, '{1'b0, 32'h08, 32'd0},
               '{1'b1, 32'h08, 32'd0}, '{1'b1, 32'h04, 32'd5}, '{1'b1, 32'h10, 32'd1},
               '{1'b1, 32'h10, 32'd0}, '{1'b0, 32'h14, 32'd0}, '{1'b0, 32'h18, 32'd0},
               '{1'b1, 32'h04, 32'd1}};

    do_reset();
    chk("reset busy",    32'(busy_o), 0);      chk("reset link_up", 32'(link_up_o), 0);
    chk("reset fail",    32'(fail_o), 0);      chk("reset err_code", 32'(err_code_o), 0);
    chk("reset retry",   32'(retry_cnt_o), 0); chk("reset err_cnt", err_cnt_o, 0);
    chk("reset wen",     32'(bus.m_wen), 0);   chk("reset ren", 32'(bus.m_ren), 0);
    chk("reset addr",    bus.m_addr, 0);       chk("sel", 32'(bus.m_sel), 32'hF);

    foreach (vecs[v]) begin
      do_reset(); cfg(vecs[v].trn_at, vecs[v].e0, vecs[v].e1, vecs[v].dat);
      pulse(1'b1, 1'b0);
      wait_idle($sformatf("vec%0d", v), 20000);
      chk($sformatf("vec%0d link_up", v),  32'(link_up_o),   32'(vecs[v].x_lu));
      chk($sformatf("vec%0d fail", v),     32'(fail_o),      32'(vecs[v].x_fail));
      chk($sformatf("vec%0d err_code", v), 32'(err_code_o),  32'(vecs[v].x_code));
      chk($sformatf("vec%0d retry", v),    32'(retry_cnt_o), 32'(vecs[v].x_retry));
      chk($sformatf("vec%0d err_cnt", v),  err_cnt_o,        vecs[v].x_ecnt);
    end

    // exact access order of a clean bring-up
    run_nominal();
    chk("nominal access count", log_q.size(), 13);
    for (int k = 0; k < 13 && k < log_q.size(); k++) begin
      chk($sformatf("txn%0d dir", k),  32'(log_q[k].we), 32'(exp_tx[k].we));
      chk($sformatf("txn%0d addr", k), log_q[k].addr,   exp_tx[k].addr);
      if (exp_tx[k].we) chk($sformatf("txn%0d data", k), log_q[k].data, exp_tx[k].data);
    end
`ifdef DAISY_LINK_CTRL_MONITOR_EN
    s_err = 32'd2;
    for (i = 0; i < 500 && err_code_o != 3'd5; i++) tick();
    chk("monitor err_code", 32'(err_code_o), 32'd5);
    chk("monitor err_cnt", err_cnt_o, 32'd2);
    chk("monitor link_up", 32'(link_up_o), 0);
    n = log_q.size(); while (n > 0 && log_q[n-1].addr == 32'h14) n--;
    wait_log("monitor", log_q.size() + 1, 20);
    chk("monitor retry write addr", log_q[log_q.size()-1].addr, 32'h00);
    chk("monitor retry write data", log_q[log_q.size()-1].data, 32'h00);
`else
    repeat (100) tick();
    chk("static link_up no traffic", log_q.size(), 13);
    chk("static link_up held", 32'(link_up_o), 1);
`endif

    // stop and start together while up: stop wins
    run_nominal();
    n = log_q.size();
    pulse(1'b1, 1'b1);
    wait_idle("stop+start", 500);
    repeat (20) tick();
    chk("stop+start accesses", log_q.size(), n + 1);
    chk("stop+start addr", log_q[log_q.size()-1].addr, 32'h00);
    chk("stop+start data", log_q[log_q.size()-1].data, 32'h00);
    chk("stop+start link_up", 32'(link_up_o), 0);
    chk("stop+start busy", 32'(busy_o), 0);

    // stop while the self-test is running
    do_reset(); cfg(3, 32'd0, 32'd0, 32'd5000); pulse(1'b1, 1'b0);
    wait_log("stop in test", 10, 500);
    repeat (5) tick();
    pulse(1'b0, 1'b1);
    wait_idle("stop in test", 500);
    repeat (100) tick();
    chk("stop in test accesses", log_q.size(), 11);
    chk("stop in test addr", log_q[log_q.size()-1].addr, 32'h00);
    chk("stop in test we", 32'(log_q[log_q.size()-1].we), 1);
    chk("stop in test link_up", 32'(link_up_o), 0);

    // slave never acks the first 0x04 write
    do_reset(); cfg(3, 32'd0, 32'd0, 32'd5000); noack_04 = 1'b1; pulse(1'b1, 1'b0);
    for (i = 0; i < 1000 && !fail_o; i++) tick();
    chk("timeout latency", cyc - strobe_cyc, BUS_TMO + 1);
    chk("timeout err_code", 32'(err_code_o), 32'd1);
    chk("timeout busy", 32'(busy_o), 0);
    chk("timeout retry", 32'(retry_cnt_o), 0);
    n = n_strobe;
    repeat (300) tick();
    chk("timeout no more strobes", n_strobe, n);
    chk("timeout accesses", log_q.size(), 2);

    // async reset while a strobe is on the bus
    do_reset(); cfg(3, 32'd0, 32'd0, 32'd5000); pulse(1'b1, 1'b0);
    for (i = 0; i < 50; i++) begin @(posedge clk); #1; if (bus.m_wen) break; end
    chk("strobe before reset", 32'(bus.m_wen), 1);
    n = log_q.size();
    rst_n = 1'b0; #1;
    chk("reset drops wen", 32'(bus.m_wen), 0);
    chk("reset drops busy", 32'(busy_o), 0);
    tick();
    chk("reset hides access", log_q.size(), n);
    rst_n = 1'b1;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
